pla_tt_sweeper: RTL and testbench
=================================

// Module: pla_tt_sweeper
// PURPOSE
// - Reader side of a 9-input/1-output combinational PLA netlist (ports x0..x8 -> y0).
// - Drives all 512 input vectors in ascending order and samples y0 after a programmable settle time.
// - Packs the results into 32-bit truth-table words and streams them out over a valid/ready interface.
// - Used for on-chip equivalence signatures of optimised PLA netlists.
// PARAMETERS
// - SETTLE_CYCLES  default 2   cycles x is held stable before y is sampled; legal range 1..15
// - NUM_INPUTS     default 9   address width; words = 2**NUM_INPUTS/32, so NUM_INPUTS >= 5
// PORTS
// - clk         in   1   single clock, rising edge
// - rst         in   1   synchronous, active-high reset
// - start       in   1   one-cycle pulse, begins a sweep; ignored unless state==IDLE or DONE
// - busy        out  1   high from the cycle after an accepted start until the last word is accepted
// - done        out  1   one-cycle pulse, the cycle after the last word handshake
// - x           out  9   vector driven to the netlist under test (x[0]=x0 ... x[8]=x8)
// - y           in   1   netlist output y0, sampled synchronously
// - word_data   out  32  bit i = y at address 32*word_index+i
// - word_index  out  4   index of word_data, 0..15
// - word_valid  out  1   word_data/word_index valid
// - word_ready  in   1   sink accepts when word_valid&&word_ready at a rising edge
// BEHAVIOUR
// - Reset values: busy=0, done=0, x=0, word_data=0, word_index=0, word_valid=0; FSM=IDLE; all counters 0.
// - FSM states: IDLE -> SETTLE -> SAMPLE -> (PUSH when addr[4:0]==31) -> SETTLE ... -> DONE -> IDLE.
// - IDLE: x holds 0; start -> SETTLE with addr=0, settle counter=0.
// - SETTLE: x=addr; stay for SETTLE_CYCLES cycles (counter 0..SETTLE_CYCLES-1), then -> SAMPLE.
// - SAMPLE: shift register bit addr[4:0] <= y.
//   - If addr[4:0]!=31: addr++ and go to SETTLE.
//   - Else: go to PUSH with word_data = completed word and word_index = addr[8:5].
// - Per-address cost: SETTLE_CYCLES+1 cycles. Best-case sweep length: 512*(SETTLE_CYCLES+1) + 16 cycles.
// - PUSH: word_valid=1; word_data and word_index are held stable until the handshake.
//   - On handshake: word_valid=0 on the next cycle.
//   - If addr==511 -> DONE, else addr++ -> SETTLE.
//   - Stall in PUSH indefinitely while word_ready=0; x holds its last value.
// - word_valid never depends combinationally on word_ready. At most one word is outstanding; no internal FIFO.
// - DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
//   - A start in the DONE cycle is accepted (back-to-back sweeps).
// - start while busy: ignored, no side effects.
// - addr wrap: addr never exceeds 511; no increment after 511.
// - rst mid-sweep: returns to IDLE next cycle, all outputs to reset values, partial word discarded, no done pulse.
// - rst has priority over start in the same cycle.
// CONFIGURATION
// - Macro TT_ONSET_COUNT_EN:
//   - Defined: adds output port onset_count (out, 10 bits), the number of sampled y==1 during the current sweep.
//     - Cleared on accepted start and on rst.
//     - Increments in SAMPLE when y=1; saturates at 512.
//     - Final value is valid and stable from the done pulse until the next accepted start.
//   - Undefined: port and counter are absent; all other behaviour is identical.
// TESTING
// - y tied 1, word_ready=1: 16 words of 0xFFFFFFFF, indices 0..15 in order, one done pulse; onset_count=512 if TT_ONSET_COUNT_EN.
// - y=x[0]: every word is 0xAAAAAAAA. y=x[5]: even words 0x00000000, odd words 0xFFFFFFFF; onset_count=256.
// - y=x0&x1&x2&x3&x4&x5&x6&x7&x8 with SETTLE_CYCLES=1: words 0..14 = 0, word 15 = 0x80000000; onset_count=1.
//   Sweep length 512*2+16 = 1040 cycles from start to done.
// - Backpressure: word_ready low for 7 cycles at word 3 -> word_data/word_index stable, x frozen, no word lost or duplicated.
// - start pulsed while busy at address 100 -> ignored. rst at address 300 -> IDLE next cycle, outputs at reset values, no done.
//   A subsequent start performs a full sweep.
// - start in the DONE cycle -> a second sweep begins with no idle gap and produces an identical word stream.

Source files
------------

// File: rtl/pla_tt_sweeper_if.sv
// Truth-table word stream between pla_tt_sweeper (master) and its sink (slave).
interface pla_tt_sweeper_if #(
  parameter int unsigned NUM_INPUTS = 9
);
  localparam int unsigned IDX_W = NUM_INPUTS - 5;

  logic [31:0]      word_data;
  logic [IDX_W-1:0] word_index;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_data, output word_index, output word_valid, input word_ready);
  modport slave  (input word_data, input word_index, input word_valid, output word_ready);
endinterface

// File: rtl/pla_tt_sweeper.sv
// Sweeps every input vector of a PLA netlist, samples its output and streams 32-bit truth-table words.
// Optional feature macro TT_ONSET_COUNT_EN adds o_onset_count (number of y==1 samples in the sweep).
module pla_tt_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_INPUTS    = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [NUM_INPUTS-1:0] o_x,
  input  logic                  i_y,
`ifdef TT_ONSET_COUNT_EN
  output logic [NUM_INPUTS:0]   o_onset_count,
`endif
  pla_tt_sweeper_if.master      m_word
);

  localparam int unsigned ADDR_W    = NUM_INPUTS;
  localparam int unsigned IDX_W     = NUM_INPUTS - 5;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LAST_ADDR = (1 << NUM_INPUTS) - 1;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(LAST_ADDR);
  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_PUSH,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [30:0]       r_shift;
  logic [ADDR_W-1:0] r_x;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_data;
  logic [IDX_W-1:0]  r_index;
  logic              r_valid;

  logic w_start_acc;
  logic w_last_bit;

  assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_bit  = (r_addr[4:0] == 5'd31);

  // Sweep sequencer; bit 31 of each word bypasses the shift register straight into r_data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_x     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_x <= '0;
          if (w_start_acc) begin
            r_state <= S_SETTLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_END) begin
            r_cnt   <= '0;
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          if (!w_last_bit) begin
            r_shift[r_addr[4:0]] <= i_y;
            r_addr  <= r_addr + ADDR_W'(1);
            r_x     <= r_addr + ADDR_W'(1);
            r_state <= S_SETTLE;
          end else begin
            r_data  <= {i_y, r_shift};
            r_index <= IDX_W'(r_addr >> 5);
            r_valid <= 1'b1;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (m_word.word_ready) begin
            r_valid <= 1'b0;
            if (r_addr == ADDR_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_x     <= r_addr + ADDR_W'(1);
              r_state <= S_SETTLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TT_ONSET_COUNT_EN
  localparam int unsigned ONS_W     = NUM_INPUTS + 1;
  localparam int unsigned ONSET_MAX = 1 << NUM_INPUTS;

  logic [ONS_W-1:0] r_onset;

  // Ones counter; holds its final value after the sweep until the next accepted start.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_acc) begin
      r_onset <= '0;
    end else if ((r_state == S_SAMPLE) && i_y && (r_onset != ONS_W'(ONSET_MAX))) begin
      r_onset <= r_onset + ONS_W'(1);
    end
  end

  assign o_onset_count = r_onset;
`endif

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_x               = r_x;
  assign m_word.word_data  = r_data;
  assign m_word.word_index = r_index;
  assign m_word.word_valid = r_valid;

endmodule

// File: tb/tb_pla_tt_sweeper.sv
// Self-checking bench for pla_tt_sweeper: several PLA functions, backpressure, start-while-busy,
// mid-sweep reset and back-to-back sweeps, checked against an address-level truth-table model.
module tb_pla_tt_sweeper;

  localparam int S     = 2;
  localparam int NADDR = 512;
  localparam int NW    = 16;
  localparam int LIMIT = 4000;
  localparam int BASE_LEN = NADDR * (S + 1) + NW;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       y;
  logic [8:0] x;
  logic       busy;
  logic       done;
`ifdef TT_ONSET_COUNT_EN
  logic [9:0] onset;
`endif

  int errors = 0;
  int checks = 0;
  int mode   = 0;
  bit tt [NADDR];

  pla_tt_sweeper_if #(.NUM_INPUTS(9)) u_if ();

  pla_tt_sweeper #(.SETTLE_CYCLES(S), .NUM_INPUTS(9)) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .o_x           (x),
    .i_y           (y),
`ifdef TT_ONSET_COUNT_EN
    .o_onset_count (onset),
`endif
    .m_word        (u_if)
  );

  always #5 clk = ~clk;

  // Netlist under test: selected by mode.
  always_comb begin
    case (mode)
      0:       y = 1'b1;
      1:       y = x[0];
      2:       y = x[5];
      3:       y = &x;
      default: y = tt[x];
    endcase
  end

  function automatic bit ref_y(input int m, input int a);
    case (m)
      0:       return 1'b1;
      1:       return bit'(a % 2);
      2:       return bit'((a / 32) % 2);
      3:       return a == NADDR - 1;
      default: return tt[a];
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input int m, input int w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = ref_y(m, 32 * w + i);
    return r;
  endfunction

`ifdef TT_ONSET_COUNT_EN
  function automatic int ref_onset(input int m);
    int n = 0;
    for (int a = 0; a < NADDR; a++) n += int'(ref_y(m, a));
    return n;
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one sweep from the current negedge. stall_idx: word held off 7 cycles (-1 none);
  // poke_at: address at which a stray start is pulsed (-1 none); chain: start again in the done cycle.
  task automatic sweep(input int m, input int stall_idx, input int poke_at, input bit chain);
    int          cyc, nwords, stall_left;
    bit          got_done, poked;
    logic [31:0] held_data;
    logic [8:0]  held_x;
    mode       = m;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cyc        = 0;
    nwords     = 0;
    stall_left = 7;
    got_done   = 1'b0;
    poked      = 1'b0;
    held_data  = '0;
    held_x     = '0;
    while (!got_done && cyc < LIMIT) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        chk("busy_during_sweep", 32'(busy), 32'd1);
        if (poke_at >= 0 && !poked && x == 9'(poke_at)) begin
          start = 1'b1;
          poked = 1'b1;
        end else begin
          start = 1'b0;
        end
        if (u_if.word_valid) begin
          if (stall_idx == nwords && stall_left > 0) begin
            if (stall_left == 7) begin
              held_data = u_if.word_data;
              held_x    = x;
            end else begin
              chk("stall_data_stable", u_if.word_data, held_data);
              chk("stall_x_frozen", 32'(x), 32'(held_x));
            end
            u_if.word_ready = 1'b0;
            stall_left--;
          end else begin
            u_if.word_ready = 1'b1;
            chk("word_index", 32'(u_if.word_index), 32'(nwords));
            chk("word_data", u_if.word_data, ref_word(m, nwords));
            nwords++;
          end
        end else begin
          u_if.word_ready = 1'b1;
        end
      end
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("sweep_length", 32'(cyc), 32'(BASE_LEN + ((stall_idx >= 0) ? 7 : 0)));
    chk("word_count", 32'(nwords), 32'(NW));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("valid_at_done", 32'(u_if.word_valid), 32'd0);
`ifdef TT_ONSET_COUNT_EN
    chk("onset_at_done", 32'(onset), 32'(ref_onset(m)));
`endif
    if (chain) begin
      start = 1'b1;
    end else begin
      start = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_x", 32'(x), 32'd0);
`ifdef TT_ONSET_COUNT_EN
      chk("onset_stable", 32'(onset), 32'(ref_onset(m)));
`endif
    end
  endtask

  initial begin
    int n;
    int done_cnt;
    rst             = 1'b1;
    start           = 1'b0;
    u_if.word_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_data", u_if.word_data, 32'd0);
    chk("rst_index", 32'(u_if.word_index), 32'd0);
    chk("rst_valid", 32'(u_if.word_valid), 32'd0);
`ifdef TT_ONSET_COUNT_EN
    chk("rst_onset", 32'(onset), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    sweep(0, -1, -1, 1'b0);
    sweep(1, -1, -1, 1'b1);
    sweep(1, -1, -1, 1'b0);
    sweep(2, 3, -1, 1'b0);
    sweep(3, -1, 100, 1'b0);

    for (int a = 0; a < NADDR; a++) tt[a] = bit'($urandom_range(0, 1));
    sweep(4, -1, -1, 1'b0);

    // Reset in the middle of a sweep.
    mode  = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    while (x != 9'd300 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("reach_addr_300", 32'(x), 32'd300);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_x", 32'(x), 32'd0);
    chk("midrst_valid", 32'(u_if.word_valid), 32'd0);
    chk("midrst_data", u_if.word_data, 32'd0);
    chk("midrst_index", 32'(u_if.word_index), 32'd0);
`ifdef TT_ONSET_COUNT_EN
    chk("midrst_onset", 32'(onset), 32'd0);
`endif
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("midrst_stays_idle", 32'(done_cnt), 32'd0);

    sweep(4, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
